// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle control unit
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
    localparam logic [1:0] PCSRC_JUMP      = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - combinational aluop/funct to ALU function code decode
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for address and branch work, funct decode for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alucontrol = ALU_ADD;
                    FUNCT_SUB: alucontrol = ALU_SUB;
                    FUNCT_AND: alucontrol = ALU_AND;
                    FUNCT_OR:  alucontrol = ALU_OR;
                    FUNCT_SLT: alucontrol = ALU_SLT;
                    default:   alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle Moore control FSM; MC_BNE_EN adds bne support
module mc_controller
    import mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op
);

    state_t     state;
    state_t     decode_next;
    logic [1:0] aluop;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       pcen_raw;
    logic       regwrite_raw;
    logic       illegal_raw;

    // Opcode dispatch out of DECODE; anything unsupported falls back to FETCH
    always_comb begin
        decode_next = S_FETCH;
        case (op)
            OP_LW, OP_SW: decode_next = S_MEMADR;
            OP_RTYPE:     decode_next = S_RTYPEEX;
            OP_BEQ:       decode_next = S_BEQEX;
            OP_ADDI:      decode_next = S_ADDIEX;
            OP_J:         decode_next = S_JEX;
`ifdef MC_BNE_EN
            OP_BNE:       decode_next = S_BNEEX;
`endif
            default:      decode_next = S_FETCH;
        endcase
    end

    // State register; reset abandons any partial instruction
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= state_t'(RESET_STATE);
        end else begin
            case (state)
                S_FETCH:   if (mem_ready) state <= S_DECODE;
                S_DECODE:  state <= decode_next;
                S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   if (mem_ready) state <= S_MEMWB;
                S_MEMWB:   state <= S_FETCH;
                S_MEMWR:   if (mem_ready) state <= S_FETCH;
                S_RTYPEEX: state <= S_ALUWB;
                S_ALUWB:   state <= S_FETCH;
                S_BEQEX:   state <= S_FETCH;
                S_ADDIEX:  state <= S_ADDIWB;
                S_ADDIWB:  state <= S_FETCH;
                S_JEX:     state <= S_FETCH;
`ifdef MC_BNE_EN
                S_BNEEX:   state <= S_FETCH;
`endif
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Moore output decode; FETCH writes wait on mem_ready, branches use zero
    always_comb begin
        iord         = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        pcen_raw     = 1'b0;
        regwrite_raw = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_B;
        pcsrc        = PCSRC_ALURESULT;
        aluop        = ALUOP_ADD;
        illegal_raw  = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb     = SRCB_FOUR;
                irwrite_raw = mem_ready;
                pcen_raw    = mem_ready;
            end
            S_DECODE: begin
                alusrcb     = SRCB_IMMSH2;
                illegal_raw = (decode_next == S_FETCH);
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                pcen_raw = zero;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                pcen_raw = ~zero;
            end
`endif
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB: regwrite_raw = 1'b1;
            S_JEX: begin
                pcsrc    = PCSRC_JUMP;
                pcen_raw = 1'b1;
            end
            default: begin
                alusrcb = SRCB_FOUR;
            end
        endcase
    end

    // Write enables and the illegal pulse are held off for the whole reset window
    always_comb begin
        irwrite    = irwrite_raw  & reset_n;
        memwrite   = memwrite_raw & reset_n;
        pcen       = pcen_raw     & reset_n;
        regwrite   = regwrite_raw & reset_n;
        illegal_op = illegal_raw  & reset_n;
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed scoreboard bench for mc_controller
module tb_mc_controller;

    localparam int FE = 0, DE = 1, MA = 2, MRD = 3, MWB = 4, MWR = 5;
    localparam int RX = 6, AWB = 7, BX = 8, AX = 9, IWB = 10, JX = 11, NX = 12;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;

    int checks = 0;
    int failures = 0;

    logic [15:0] sb[$];
    string       tq[$];

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal_op (illegal_op)
    );

    function automatic logic [2:0] fdec(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic legal(input logic [5:0] o);
        case (o)
            6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MC_BNE_EN
            6'b000101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Expected output vector for a state given the inputs in that cycle
    function automatic logic [15:0] model(input int st, input logic mr, input logic z);
        logic e_iord, e_irw, e_mw, e_pcen, e_rw, e_rd, e_m2r, e_sa, e_ill;
        logic [1:0] e_sb, e_ps;
        logic [2:0] e_alu;
        e_iord = 0; e_irw = 0; e_mw = 0; e_pcen = 0; e_rw = 0; e_rd = 0;
        e_m2r = 0; e_sa = 0; e_ill = 0; e_sb = 2'b00; e_ps = 2'b00; e_alu = 3'b010;
        case (st)
            FE:  begin e_sb = 2'b01; e_irw = mr; e_pcen = mr; end
            DE:  begin e_sb = 2'b11; e_ill = ~legal(op); end
            MA:  begin e_sa = 1; e_sb = 2'b10; end
            MRD: e_iord = 1;
            MWB: begin e_m2r = 1; e_rw = 1; end
            MWR: begin e_iord = 1; e_mw = 1; end
            RX:  begin e_sa = 1; e_alu = fdec(funct); end
            AWB: begin e_rd = 1; e_rw = 1; end
            BX:  begin e_sa = 1; e_alu = 3'b110; e_ps = 2'b01; e_pcen = z; end
            NX:  begin e_sa = 1; e_alu = 3'b110; e_ps = 2'b01; e_pcen = ~z; end
            AX:  begin e_sa = 1; e_sb = 2'b10; end
            IWB: e_rw = 1;
            JX:  begin e_ps = 2'b10; e_pcen = 1; end
            default: ;
        endcase
        return {e_iord, e_irw, e_mw, e_pcen, e_rw, e_rd, e_m2r, e_sa, e_sb, e_ps, e_alu, e_ill};
    endfunction

    task automatic compare_head();
        logic [15:0] obs, exp;
        string tag;
        obs = {iord, irwrite, memwrite, pcen, regwrite, regdst, memtoreg, alusrca,
               alusrcb, pcsrc, alucontrol, illegal_op};
        exp = sb.pop_front();
        tag = tq.pop_front();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One cycle in a known state: drive, predict, sample at negedge, advance
    task automatic step(input int st, input logic mr, input logic z, input string tag);
        mem_ready = mr;
        zero = z;
        sb.push_back(model(st, mr, z));
        tq.push_back(tag);
        @(negedge clk);
        compare_head();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        #12;
        sb.push_back(model(FE, 1'b0, 1'b0));
        tq.push_back("reset_outputs");
        compare_head();
        mem_ready = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // fetch stall then R-type add
        op = 6'b000000; funct = 6'b100000;
        step(FE, 0, 0, "fetch_stall0");
        step(FE, 0, 0, "fetch_stall1");
        step(FE, 1, 0, "add_fetch");
        step(DE, 1, 0, "add_decode");
        step(RX, 1, 0, "add_ex");
        step(AWB, 1, 0, "add_wb");

        // R-type slt and an unknown funct
        funct = 6'b101010;
        step(FE, 1, 0, "slt_fetch"); step(DE, 1, 0, "slt_decode");
        step(RX, 1, 0, "slt_ex");    step(AWB, 1, 0, "slt_wb");
        funct = 6'b111111;
        step(FE, 1, 0, "xf_fetch"); step(DE, 1, 0, "xf_decode");
        step(RX, 1, 0, "xf_ex");    step(AWB, 1, 0, "xf_wb");

        // lw with three wait cycles on the read
        op = 6'b100011;
        step(FE, 1, 0, "lw_fetch"); step(DE, 1, 0, "lw_decode"); step(MA, 1, 0, "lw_adr");
        for (int i = 0; i < 3; i++) step(MRD, 0, 0, "lw_rd_wait");
        step(MRD, 1, 0, "lw_rd"); step(MWB, 1, 0, "lw_wb");

        // beq taken and not taken
        op = 6'b000100;
        step(FE, 1, 0, "beq1_fetch"); step(DE, 1, 0, "beq1_decode"); step(BX, 1, 1, "beq1_ex");
        step(FE, 1, 0, "beq0_fetch"); step(DE, 1, 1, "beq0_decode"); step(BX, 1, 0, "beq0_ex");

        // sw with two wait cycles on the write
        op = 6'b101011;
        step(FE, 1, 0, "sw_fetch"); step(DE, 1, 0, "sw_decode"); step(MA, 1, 0, "sw_adr");
        step(MWR, 0, 0, "sw_wr_wait0"); step(MWR, 0, 0, "sw_wr_wait1"); step(MWR, 1, 0, "sw_wr");

        // j and addi
        op = 6'b000010;
        step(FE, 1, 0, "j_fetch"); step(DE, 1, 0, "j_decode"); step(JX, 0, 0, "j_ex");
        op = 6'b001000;
        step(FE, 1, 0, "addi_fetch"); step(DE, 1, 0, "addi_decode");
        step(AX, 1, 0, "addi_ex");    step(IWB, 1, 0, "addi_wb");

        // illegal opcode pulse for one cycle
        op = 6'b111111;
        step(FE, 1, 0, "ill_fetch"); step(DE, 1, 0, "ill_decode");
        step(FE, 0, 0, "ill_after");

        // bne: branch when enabled, illegal otherwise
        op = 6'b000101;
        step(FE, 1, 0, "bne_fetch"); step(DE, 1, 0, "bne_decode");
`ifdef MC_BNE_EN
        step(NX, 1, 0, "bne_ex_z0");
        step(FE, 1, 0, "bne2_fetch"); step(DE, 1, 0, "bne2_decode"); step(NX, 1, 1, "bne_ex_z1");
`else
        step(FE, 0, 0, "bne_after");
`endif

        // reset asserted in the middle of a stalled store
        op = 6'b101011;
        step(FE, 1, 0, "rsw_fetch"); step(DE, 1, 0, "rsw_decode"); step(MA, 1, 0, "rsw_adr");
        step(MWR, 0, 0, "rsw_wr_wait");
        reset_n = 1'b0;
        #1;
        sb.push_back(model(FE, 1'b0, 1'b0));
        tq.push_back("reset_async");
        compare_head();
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        step(FE, 0, 0, "after_reset");
        step(FE, 1, 0, "after_reset_go");
        step(DE, 1, 0, "after_reset_decode");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
